// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the data-memory address decode.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [31:0] LSU_DATA_BEGIN = 32'h0000_2000;
    localparam logic [31:0] LSU_DATA_END   = 32'h0000_3FFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        RESPOND
    } lsu_state_t;

    // Byte-lane mask for an access of the given size starting at lane 0.
    function automatic logic [15:0] size_mask(input logic [1:0] size);
        logic [15:0] m;
        case (size)
            SIZE_B:  m = 16'h0001;
            SIZE_H:  m = 16'h0003;
            SIZE_W:  m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Shifts a two-beat read window down to the access offset, keeps the access
// size and sign- or zero-extends to 64 bits. Purely combinational.
module load_align_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_lo,
    input  logic [63:0] i_hi,
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    logic [63:0] w_raw;
    logic        w_unsigned;

    assign w_raw      = 64'({i_hi, i_lo} >> {i_off, 3'b000});
    assign w_unsigned = i_funct3[2];

    always_comb begin
        o_data = w_raw;
        case (i_funct3[1:0])
            SIZE_B:  o_data = w_unsigned ? {56'b0, w_raw[7:0]}
                                         : {{56{w_raw[7]}}, w_raw[7:0]};
            SIZE_H:  o_data = w_unsigned ? {48'b0, w_raw[15:0]}
                                         : {{48{w_raw[15]}}, w_raw[15:0]};
            SIZE_W:  o_data = w_unsigned ? {32'b0, w_raw[31:0]}
                                         : {{32{w_raw[31]}}, w_raw[31:0]};
            default: o_data = w_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side data-memory initiator: one load/store per transaction, misaligned
// accesses split into two 64-bit beats, loads merged and extended.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// ISSUE_LO | first (or only) beat strobe on the memory port
// WAIT_LO  | load: first beat read data arrives this cycle
// ISSUE_HI | second beat strobe of a split access
// WAIT_HI  | load: second beat read data arrives this cycle
// RESPOND  | resp_valid pulse, back to IDLE next cycle
module load_store_unit #(
    parameter logic [31:0] DATA_BEGIN = lsu_pkg::LSU_DATA_BEGIN,
    parameter logic [31:0] DATA_END   = lsu_pkg::LSU_DATA_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [63:0] req_write_data,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [63:0] resp_read_data,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_byte_mask,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);
    import lsu_pkg::*;

    lsu_state_t r_state;
    lsu_state_t w_next_state;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic        r_split;
    logic [7:0]  r_mask_hi;
    logic [63:0] r_wdata_hi;
    logic [31:0] r_beat_addr;
    logic [63:0] r_lo;

    logic [2:0]   w_off;
    logic [3:0]   w_size;
    logic         w_split;
    logic [15:0]  w_mask;
    logic [127:0] w_wdata;
    logic [32:0]  w_last;
    logic         w_fault;
    logic         w_illegal;
    logic [31:0]  w_hi_addr;

    logic [63:0] w_align_lo;
    logic [63:0] w_align_hi;
    logic [63:0] w_load_result;

    logic        w_ready_d;
    logic        w_rd_en_d;
    logic        w_wr_en_d;
    logic [31:0] w_addr_d;
    logic [7:0]  w_mask_d;
    logic [63:0] w_wdata_d;
    logic        w_resp_valid_d;
    logic        w_resp_error_d;
    logic [63:0] w_resp_data_d;

    assign w_off     = req_address[2:0];
    assign w_size    = 4'd1 << req_funct3[1:0];
    assign w_split   = ({1'b0, w_off} + w_size) > 4'd8;
    assign w_mask    = size_mask(req_funct3[1:0]) << w_off;
    assign w_wdata   = {64'b0, req_write_data} << {w_off, 3'b000};
    // 33-bit end address so an access near 4 GiB cannot wrap into range.
    assign w_last    = {1'b0, req_address} + {29'b0, w_size} - 33'd1;
    assign w_fault   = (req_address < DATA_BEGIN) || (w_last > {1'b0, DATA_END});
    assign w_illegal = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
    assign w_hi_addr = r_beat_addr + 32'd8;

    // Read data is merged straight off the port so the response is ready the
    // cycle after the last beat; an aligned access sees a zero high beat.
    assign w_align_lo = (r_state == WAIT_HI) ? r_lo : mem_read_data;
    assign w_align_hi = (r_state == WAIT_HI) ? mem_read_data : 64'b0;

    load_align_extend u_align (
        .i_lo     (w_align_lo),
        .i_hi     (w_align_hi),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_result)
    );

    always_comb begin
        w_next_state   = r_state;
        w_rd_en_d      = 1'b0;
        w_wr_en_d      = 1'b0;
        w_addr_d       = '0;
        w_mask_d       = '0;
        w_wdata_d      = '0;
        w_resp_valid_d = 1'b0;
        w_resp_error_d = 1'b0;
        w_resp_data_d  = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_fault || w_illegal) begin
                        w_next_state   = RESPOND;
                        w_resp_valid_d = 1'b1;
                        w_resp_error_d = 1'b1;
                    end else begin
                        w_next_state = ISSUE_LO;
                        w_rd_en_d    = !req_write;
                        w_wr_en_d    = req_write;
                        w_addr_d     = {req_address[31:3], 3'b000};
                        w_mask_d     = w_mask[7:0];
                        w_wdata_d    = w_wdata[63:0];
                    end
                end
            end
            ISSUE_LO: begin
                if (!r_write) begin
                    w_next_state = WAIT_LO;
                end else if (r_split) begin
                    w_next_state = ISSUE_HI;
                    w_wr_en_d    = 1'b1;
                    w_addr_d     = w_hi_addr;
                    w_mask_d     = r_mask_hi;
                    w_wdata_d    = r_wdata_hi;
                end else begin
                    w_next_state   = RESPOND;
                    w_resp_valid_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (r_split) begin
                    w_next_state = ISSUE_HI;
                    w_rd_en_d    = 1'b1;
                    w_addr_d     = w_hi_addr;
                    w_mask_d     = r_mask_hi;
                end else begin
                    w_next_state   = RESPOND;
                    w_resp_valid_d = 1'b1;
                    w_resp_data_d  = w_load_result;
                end
            end
            ISSUE_HI: begin
                if (r_write) begin
                    w_next_state   = RESPOND;
                    w_resp_valid_d = 1'b1;
                end else begin
                    w_next_state = WAIT_HI;
                end
            end
            WAIT_HI: begin
                w_next_state   = RESPOND;
                w_resp_valid_d = 1'b1;
                w_resp_data_d  = w_load_result;
            end
            RESPOND:  w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    assign w_ready_d = (w_next_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_read_data <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_address    <= '0;
            mem_byte_mask  <= '0;
            mem_write_data <= '0;
            r_write        <= 1'b0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_split        <= 1'b0;
            r_mask_hi      <= '0;
            r_wdata_hi     <= '0;
            r_beat_addr    <= '0;
            r_lo           <= '0;
        end else begin
            r_state        <= w_next_state;
            req_ready      <= w_ready_d;
            resp_valid     <= w_resp_valid_d;
            resp_error     <= w_resp_error_d;
            resp_read_data <= w_resp_data_d;
            mem_read_en    <= w_rd_en_d;
            mem_write_en   <= w_wr_en_d;
            mem_address    <= w_addr_d;
            mem_byte_mask  <= w_mask_d;
            mem_write_data <= w_wdata_d;
            if (r_state == IDLE && req_valid) begin
                r_write     <= req_write;
                r_funct3    <= req_funct3;
                r_off       <= w_off;
                r_split     <= w_split;
                r_mask_hi   <= w_mask[15:8];
                r_wdata_hi  <= w_wdata[127:64];
                r_beat_addr <= {req_address[31:3], 3'b000};
            end
            if (r_state == WAIT_LO) begin
                r_lo <= mem_read_data;
            end
        end
    end

endmodule
